mi_ram_responder: RTL and testbench
===================================

// Module: mi_ram_responder
// PURPOSE
// - Memory-interface (mi_*) responder: services burst read/write commands from a mi_* initiator
//   (memtest, video DMA) out of on-chip EBR rather than external SPI/HyperRAM.
// - Drop-in for the memory controller in memtest builds without external RAM, and a reference
//   target for initiator verification.
// - Optional LFSR-driven stall injection emulates controller back-pressure; Wishbone CSRs give
//   control and burst counters.
// PARAMETERS
// - AW      10        log2 of memory depth in 32-bit words; mi_addr[AW-1:0] indexes, upper bits ignored
// - SEED    16'hACE1  LFSR reset value; must be non-zero
// PORTS
// - clk       in   1   system clock (clk_1x domain); single clock
// - rst       in   1   synchronous, active-high reset
// - mi_addr   in   32  burst start address, 32-bit word units
// - mi_len    in   7   burst length minus 1 (1..128 words)
// - mi_rw     in   1   1=read, 0=write
// - mi_valid  in   1   command valid
// - mi_ready  out  1   command accept
// - mi_wdata  in   32  write word; must be valid while the burst is in progress
// - mi_wack   out  1   write word consumed this cycle
// - mi_wlast  out  1   with mi_wack: last word of the burst
// - mi_rdata  out  32  read word
// - mi_rstb   out  1   mi_rdata valid this cycle
// - mi_rlast  out  1   with mi_rstb: last word of the burst
// - wb_addr   in   2   CSR select
// - wb_wdata  in   32  CSR write data
// - wb_rdata  out  32  CSR read data; zero when wb_ack=0
// - wb_we     in   1   write enable
// - wb_cyc    in   1   cycle
// - wb_ack    out  1   acknowledge
// BEHAVIOUR
// - Reset values: all outputs 0; FSM=IDLE; counters 0; CSR0 = 0; LFSR=SEED. Memory contents are
//   not cleared.
// - FSM states: IDLE, WR, RD, DRAIN, TURN.
//   - IDLE: mi_ready=1 (combinational from state). On mi_valid&mi_ready: latch addr[AW-1:0], cnt=mi_len,
//     rw. Next state is RD if rw=1, else WR.
//   - WR, per non-stalled cycle:
//     - mi_wack=1 and mem[addr]<=mi_wdata, sampled in the same cycle; addr++, cnt--.
//     - mi_wlast=1 when cnt==0; then go to TURN.
//     - mi_wack and mi_wlast are combinational from state, cnt and stall.
//   - RD, per non-stalled cycle:
//     - Issue EBR read of mem[addr]; addr++, cnt--.
//     - Data returns 1 cycle later on registered mi_rdata with mi_rstb=1; mi_rlast set for the
//       cnt==0 issue.
//     - After the last issue go to DRAIN.
//   - DRAIN: wait one cycle for the last mi_rstb, then go to TURN.
//   - TURN: one idle cycle with mi_ready=0, then go to IDLE. Min command spacing is 1 dead cycle.
// - Latency: handshake at cycle T.
//   - Earliest mi_wack at T+1.
//   - Earliest mi_rstb at T+2.
//   - Without stalls, consecutive words stream one per cycle.
// - Address arithmetic: AW-bit, wraps modulo 2^AW inside a burst (addr 2^AW-1 -> 0).
// - Stall:
//   - When CSR0.en=1, a WR/RD cycle is stalled if lfsr[3:0] < CSR0.density.
//   - A stalled cycle produces no wack and no read issue.
//   - The LFSR (x^16+x^14+x^13+x^11) advances every clock.
//   - density=0 means no stalls. density=15 means 15/16 stalled, never a permanent stall.
// - Counters:
//   - CNT_WR and CNT_RD are 32-bit and increment on command handshake; they wrap at 2^32.
//   - Any Wishbone write to a counter clears it.
//   - If a clear coincides with an increment, the clear wins.
// - CSR map:
//   - 0 = CTRL: [0] stall en, [7:4] density (RW)
//   - 1 = CNT_WR
//   - 2 = CNT_RD
//   - 3 = STATUS: [0] busy (state!=IDLE), [2:0]->[3:1] state (RO)
// - Wishbone: wb_ack <= wb_cyc & ~wb_ack, giving single-cycle access with ack one cycle after cyc;
//   the write takes effect with ack.
// - A CSR0 change mid-burst applies from the next cycle. Initiator mi_valid during WR/RD/DRAIN/TURN
//   is ignored until IDLE.
// - rst mid-burst: next cycle all strobes are 0 and FSM=IDLE; the partial burst is abandoned and words
//   already written stay written.
// STRUCTURE
// - Shared header mi_defs.vh holds:
//   - state encodings (IDLE=0, WR=1, RD=2, DRAIN=3, TURN=4)
//   - CSR addresses
//   - MI_RW_READ=1'b1
//   - LFSR taps
// - Sub-module mi_ram_mem: simple dual-port inferred EBR, 2^AW x 32, 1-cycle registered read, write-first
//   not required (no same-address RD/WR overlap possible).
// - Top holds the FSM, the stall LFSR and the CSR/Wishbone logic.
// TESTING
// - Write burst: addr=0x10, len=3, wdata 0xA0..0xA3, stall off.
//   -> 4 consecutive wacks starting at T+1, wlast on the 4th only.
// - Read back addr=0x10, len=3.
//   -> rstb at T+2..T+5 with rdata A0..A3, rlast on T+5, mi_ready=0 for the TURN cycle.
// - Wrap (AW=10): write addr=0x3FE, len=3.
//   -> words land at 0x3FE, 0x3FF, 0x000, 0x001; read back matches.
// - Stall: CSR0=0x00F1 (en, density 15), 128-word write + read.
//   -> exactly 128 wacks and 128 rstbs, single wlast/rlast, data intact, completes.
// - Counters: 3 writes + 2 reads -> CNT_WR=3, CNT_RD=2; WB write to addr 1 -> CNT_WR reads 0.
// - Reset at the 2nd wack of a len=7 write.
//   -> next cycle wack=0, mi_ready=1; words 0-1 written, 2-7 unchanged; a new command is accepted normally.

Source files
------------

// File: rtl/mi_ram_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mi_ram_responder_pkg                                                       |
// | Shared types and constants for the EBR-backed mi_* memory responder:       |
// | FSM state encodings, CSR addresses, command encoding and stall LFSR taps.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mi_ram_responder_pkg;

   // Encodings are visible to software through the STATUS register.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WR    = 3'd1,
      ST_RD    = 3'd2,
      ST_DRAIN = 3'd3,
      ST_TURN  = 3'd4
   } mi_state_e;

   localparam logic [1:0] CSR_CTRL   = 2'd0;
   localparam logic [1:0] CSR_CNT_WR = 2'd1;
   localparam logic [1:0] CSR_CNT_RD = 2'd2;
   localparam logic [1:0] CSR_STATUS = 2'd3;

   localparam logic MI_RW_READ = 1'b1;

   // Taps for x^16 + x^14 + x^13 + x^11 (bits 15, 13, 12, 10).
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Fibonacci shift-left step; bit 15 is always a tap, so non-zero states stay non-zero.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/mi_ram_responder_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mi_ram_responder_mem                                                       |
// | Simple dual-port inferred EBR, 2^AW x 32, one write port and one read port |
// | with a registered (1-cycle) read. Contents are never cleared.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mi_ram_responder_mem
   import mi_ram_responder_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data
);

   logic [31:0] mem_q [2**AW];
   logic [31:0] rd_data_q;

   // Write port: the responder never reads and writes the same word in one cycle,
   // so no read/write collision ordering is needed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Registered read port; holds its last value when not enabled.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/mi_ram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mi_ram_responder                                                           |
// | mi_* burst read/write responder backed by on-chip EBR. Includes an         |
// | LFSR-driven stall injector to emulate controller back-pressure and a small |
// | Wishbone CSR block (control, write/read burst counters, status).           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mi_ram_responder
   import mi_ram_responder_pkg::*;
#(
   parameter int          AW   = 10,
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mi_addr,
   input  logic [6:0]  mi_len,
   input  logic        mi_rw,
   input  logic        mi_valid,
   output logic        mi_ready,
   input  logic [31:0] mi_wdata,
   output logic        mi_wack,
   output logic        mi_wlast,
   output logic [31:0] mi_rdata,
   output logic        mi_rstb,
   output logic        mi_rlast,
   input  logic [1:0]  wb_addr,
   input  logic [31:0] wb_wdata,
   output logic [31:0] wb_rdata,
   input  logic        wb_we,
   input  logic        wb_cyc,
   output logic        wb_ack
);

   localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

   // Burst engine state
   mi_state_e     state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [6:0]    cnt_q, cnt_d;
   logic          rstb_q, rstb_d;
   logic          rlast_q, rlast_d;

   // Stall injector
   logic [15:0]   lfsr_q, lfsr_d;
   logic          stall_en_q, stall_en_d;
   logic [3:0]    density_q, density_d;

   // CSR block
   logic [31:0]   cnt_wr_q, cnt_wr_d;
   logic [31:0]   cnt_rd_q, cnt_rd_d;
   logic          wb_ack_q, wb_ack_d;
   logic [31:0]   wb_rdata_q, wb_rdata_d;

   // Combinational helpers
   logic          stall;
   logic          handshake;
   logic          last_word;
   logic          mem_we;
   logic          rd_issue;
   logic          wb_req;
   logic          wb_wr;
   logic [31:0]   mem_rdata;

   // Upper address bits and unused CTRL write bits are intentionally ignored.
   logic          unused_bits;
   assign unused_bits = ^{mi_addr[31:AW], wb_wdata[31:8], wb_wdata[3:1]};

   mi_ram_responder_mem #(
      .AW (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (mem_we),
      .wr_addr (addr_q),
      .wr_data (mi_wdata),
      .rd_en   (rd_issue),
      .rd_addr (addr_q),
      .rd_data (mem_rdata)
   );

   // Per-cycle qualifiers shared by the FSM, the strobes and the counters.
   always_comb begin
      stall     = stall_en_q && (lfsr_q[3:0] < density_q);
      mi_ready  = (state_q == ST_IDLE);
      handshake = mi_valid && mi_ready;
      last_word = (cnt_q == 7'd0);
      mem_we    = (state_q == ST_WR) && !stall;
      rd_issue  = (state_q == ST_RD) && !stall;
      wb_req    = wb_cyc && !wb_ack_q;
      wb_wr     = wb_req && wb_we;
   end

   // Burst FSM next-state, address/count stepping and read strobe pipeline.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      rstb_d  = rd_issue;
      rlast_d = rd_issue && last_word;
      case (state_q)
         ST_IDLE: begin
            if (handshake) begin
               addr_d  = mi_addr[AW-1:0];
               cnt_d   = mi_len;
               state_d = (mi_rw == MI_RW_READ) ? ST_RD : ST_WR;
            end
         end
         ST_WR: begin
            if (!stall) begin
               addr_d = addr_q + ADDR_ONE;
               cnt_d  = cnt_q - 7'd1;
               if (last_word) begin
                  state_d = ST_TURN;
               end
            end
         end
         ST_RD: begin
            if (!stall) begin
               addr_d = addr_q + ADDR_ONE;
               cnt_d  = cnt_q - 7'd1;
               if (last_word) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         // The last read word is on the output register during this cycle.
         ST_DRAIN: state_d = ST_TURN;
         ST_TURN:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Write acknowledge is combinational so the word is consumed in the cycle it is strobed.
   assign mi_wack  = mem_we;
   assign mi_wlast = mem_we && last_word;
   assign mi_rstb  = rstb_q;
   assign mi_rlast = rlast_q;
   // Gate the EBR output so idle cycles present zero rather than stale data.
   assign mi_rdata = rstb_q ? mem_rdata : 32'd0;

   // Stall LFSR, CTRL register, burst counters and Wishbone response.
   always_comb begin
      lfsr_d     = lfsr_step(lfsr_q);
      stall_en_d = stall_en_q;
      density_d  = density_q;
      cnt_wr_d   = cnt_wr_q;
      cnt_rd_d   = cnt_rd_q;
      wb_ack_d   = wb_req;
      wb_rdata_d = 32'd0;

      if (handshake) begin
         if (mi_rw == MI_RW_READ) begin
            cnt_rd_d = cnt_rd_q + 32'd1;
         end else begin
            cnt_wr_d = cnt_wr_q + 32'd1;
         end
      end

      // Writes land on the same edge that raises ack; a counter clear overrides an increment.
      if (wb_wr) begin
         case (wb_addr)
            CSR_CTRL: begin
               stall_en_d = wb_wdata[0];
               density_d  = wb_wdata[7:4];
            end
            CSR_CNT_WR: cnt_wr_d = 32'd0;
            CSR_CNT_RD: cnt_rd_d = 32'd0;
            default: ;
         endcase
      end

      if (wb_req) begin
         case (wb_addr)
            CSR_CTRL:   wb_rdata_d = {24'd0, density_q, 3'd0, stall_en_q};
            CSR_CNT_WR: wb_rdata_d = cnt_wr_q;
            CSR_CNT_RD: wb_rdata_d = cnt_rd_q;
            default:    wb_rdata_d = {28'd0, state_q, state_q != ST_IDLE};
         endcase
      end
   end

   assign wb_ack   = wb_ack_q;
   assign wb_rdata = wb_rdata_q;

   // State register for every flop in the block; reset abandons any burst in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         cnt_q      <= 7'd0;
         rstb_q     <= 1'b0;
         rlast_q    <= 1'b0;
         lfsr_q     <= SEED;
         stall_en_q <= 1'b0;
         density_q  <= 4'd0;
         cnt_wr_q   <= 32'd0;
         cnt_rd_q   <= 32'd0;
         wb_ack_q   <= 1'b0;
         wb_rdata_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         rstb_q     <= rstb_d;
         rlast_q    <= rlast_d;
         lfsr_q     <= lfsr_d;
         stall_en_q <= stall_en_d;
         density_q  <= density_d;
         cnt_wr_q   <= cnt_wr_d;
         cnt_rd_q   <= cnt_rd_d;
         wb_ack_q   <= wb_ack_d;
         wb_rdata_q <= wb_rdata_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mi_ram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mi_ram_responder                                                        |
// | Scoreboard bench for mi_ram_responder: expected burst words are queued at  |
// | command time and popped as the responder strobes them.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mi_ram_responder;

   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mi_addr;
   logic [6:0]  mi_len;
   logic        mi_rw;
   logic        mi_valid;
   logic        mi_ready;
   logic [31:0] mi_wdata;
   logic        mi_wack;
   logic        mi_wlast;
   logic [31:0] mi_rdata;
   logic        mi_rstb;
   logic        mi_rlast;
   logic [1:0]  wb_addr;
   logic [31:0] wb_wdata;
   logic [31:0] wb_rdata;
   logic        wb_we;
   logic        wb_cyc;
   logic        wb_ack;

   always #5 clk = ~clk;

   mi_ram_responder #(
      .AW   (AW),
      .SEED (16'hACE1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mi_addr  (mi_addr),
      .mi_len   (mi_len),
      .mi_rw    (mi_rw),
      .mi_valid (mi_valid),
      .mi_ready (mi_ready),
      .mi_wdata (mi_wdata),
      .mi_wack  (mi_wack),
      .mi_wlast (mi_wlast),
      .mi_rdata (mi_rdata),
      .mi_rstb  (mi_rstb),
      .mi_rlast (mi_rlast),
      .wb_addr  (wb_addr),
      .wb_wdata (wb_wdata),
      .wb_rdata (wb_rdata),
      .wb_we    (wb_we),
      .wb_cyc   (wb_cyc),
      .wb_ack   (wb_ack)
   );

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [DEPTH];
   logic [31:0] wbuf  [128];
   int          checks   = 0;
   int          failures = 0;

   // Single Wishbone access; returns the data captured in the ack cycle.
   task automatic wb_access(input logic [1:0] a, input logic we, input logic [31:0] d,
                            output logic [31:0] q);
      int n;
      @(negedge clk);
      wb_addr  = a;
      wb_we    = we;
      wb_wdata = d;
      wb_cyc   = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!wb_ack && n < 10);
      q = wb_rdata;
      if (!wb_ack) begin
         checks++;
         failures++;
         $display("FAIL wb_ack_timeout addr=%0d", a);
      end
      wb_cyc = 1'b0;
      wb_we  = 1'b0;
   endtask

   // Issue one burst, queue its expected words, then pop/compare as strobes appear.
   task automatic run_burst(input logic [31:0] addr, input int len, input logic rd,
                            input bit timing, output int cycles);
      int   n, got, budget, base, idx;
      exp_t e;
      base = int'(addr[AW-1:0]);
      n = 0;
      @(negedge clk);
      while (!mi_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!mi_ready) begin
         checks++;
         failures++;
         $display("FAIL ready_timeout addr=%h", addr);
      end
      sb.delete();
      for (int i = 0; i <= len; i++) begin
         e.data = rd ? model[(base + i) % DEPTH] : wbuf[i];
         e.last = (i == len);
         sb.push_back(e);
      end
      mi_addr  = addr;
      mi_len   = 7'(len);
      mi_rw    = rd;
      mi_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mi_valid = 1'b0;
      cycles = 1;
      got    = 0;
      budget = 40 + (len + 1) * 40;
      while (sb.size() > 0 && cycles <= budget) begin
         if (!rd) mi_wdata = wbuf[got];
         if (rd ? mi_rstb : mi_wack) begin
            e = sb.pop_front();
            checks++;
            if (rd) begin
               if (mi_rdata !== e.data || mi_rlast !== e.last) begin
                  failures++;
                  $display("FAIL rd_word %0d addr=%h: got data=%h last=%b, want data=%h last=%b",
                           got, addr, mi_rdata, mi_rlast, e.data, e.last);
               end
            end else begin
               if (mi_wlast !== e.last) begin
                  failures++;
                  $display("FAIL wr_last word %0d addr=%h: got %b want %b",
                           got, addr, mi_wlast, e.last);
               end
               idx = (base + got) % DEPTH;
               model[idx] = wbuf[got];
            end
            if (timing) begin
               checks++;
               if (cycles !== got + (rd ? 2 : 1)) begin
                  failures++;
                  $display("FAIL latency word %0d rd=%b: got cycle T+%0d want T+%0d",
                           got, rd, cycles, got + (rd ? 2 : 1));
               end
            end
            got++;
         end
         if (rd ? mi_wack : mi_rstb) begin
            checks++;
            failures++;
            $display("FAIL wrong_strobe rd=%b at cycle T+%0d", rd, cycles);
         end
         @(negedge clk);
         cycles++;
      end
      if (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL burst_timeout addr=%h got %0d words want %0d", addr, got, len + 1);
         sb.delete();
      end
      checks++;
      if (mi_ready !== 1'b0 || mi_wack !== 1'b0 || mi_rstb !== 1'b0) begin
         failures++;
         $display("FAIL turn_cycle: got ready=%b wack=%b rstb=%b want 0 0 0",
                  mi_ready, mi_wack, mi_rstb);
      end
      @(negedge clk);
      checks++;
      if (mi_ready !== 1'b1) begin
         failures++;
         $display("FAIL idle_return: got ready=%b want 1", mi_ready);
      end
   endtask

   task automatic test_reset();
      logic [31:0] q;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (mi_wack !== 1'b0 || mi_wlast !== 1'b0 || mi_rstb !== 1'b0 || mi_rlast !== 1'b0 ||
          mi_rdata !== 32'd0 || wb_ack !== 1'b0 || wb_rdata !== 32'd0 || mi_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_outputs: wack=%b rstb=%b rdata=%h ack=%b wbr=%h ready=%b",
                  mi_wack, mi_rstb, mi_rdata, wb_ack, wb_rdata, mi_ready);
      end
      for (int a = 0; a < 4; a++) begin
         wb_access(2'(a), 1'b0, 32'd0, q);
         checks++;
         if (q !== 32'd0) begin
            failures++;
            $display("FAIL reset_csr%0d: got %h want 0", a, q);
         end
      end
   endtask

   task automatic test_write_read();
      int c;
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
      run_burst(32'h10, 3, 1'b0, 1'b1, c);
      run_burst(32'h10, 3, 1'b1, 1'b1, c);
      // Upper address bits must be ignored.
      run_burst(32'hABC0_0010, 3, 1'b1, 1'b1, c);
   endtask

   task automatic test_wrap();
      int c;
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE_0000 | i;
      run_burst(32'h3FE, 3, 1'b0, 1'b1, c);
      run_burst(32'h3FE, 3, 1'b1, 1'b1, c);
      // Words 2 and 3 must have landed at the bottom of the array.
      run_burst(32'h000, 1, 1'b1, 1'b1, c);
   endtask

   task automatic test_stall();
      logic [31:0] q;
      int          c;
      wb_access(2'd0, 1'b1, 32'hFFFF_FFFF, q);
      wb_access(2'd0, 1'b0, 32'd0, q);
      checks++;
      if (q !== 32'h0000_00F1) begin
         failures++;
         $display("FAIL ctrl_readback: got %h want 000000f1", q);
      end
      for (int i = 0; i < 128; i++) wbuf[i] = $urandom;
      run_burst(32'h100, 127, 1'b0, 1'b0, c);
      checks++;
      if (c <= 200) begin
         failures++;
         $display("FAIL stall_write_effect: got %0d cycles want more than 200", c);
      end
      run_burst(32'h100, 127, 1'b1, 1'b0, c);
      checks++;
      if (c <= 200) begin
         failures++;
         $display("FAIL stall_read_effect: got %0d cycles want more than 200", c);
      end
      wb_access(2'd0, 1'b1, 32'd0, q);
   endtask

   task automatic test_counters();
      logic [31:0] q;
      int          c;
      wb_access(2'd1, 1'b1, 32'd0, q);
      wb_access(2'd2, 1'b1, 32'd0, q);
      for (int i = 0; i < 3; i++) begin
         wbuf[0] = 32'h5000 + i;
         run_burst(32'h50 + i, 0, 1'b0, 1'b1, c);
      end
      for (int i = 0; i < 2; i++) run_burst(32'h50 + i, 0, 1'b1, 1'b1, c);
      wb_access(2'd1, 1'b0, 32'd0, q);
      checks++;
      if (q !== 32'd3) begin
         failures++;
         $display("FAIL cnt_wr: got %0d want 3", q);
      end
      wb_access(2'd2, 1'b0, 32'd0, q);
      checks++;
      if (q !== 32'd2) begin
         failures++;
         $display("FAIL cnt_rd: got %0d want 2", q);
      end
      wb_access(2'd1, 1'b1, 32'hDEAD_BEEF, q);
      wb_access(2'd1, 1'b0, 32'd0, q);
      checks++;
      if (q !== 32'd0) begin
         failures++;
         $display("FAIL cnt_wr_clear: got %0d want 0", q);
      end
      wb_access(2'd2, 1'b0, 32'd0, q);
      checks++;
      if (q !== 32'd2) begin
         failures++;
         $display("FAIL cnt_rd_kept: got %0d want 2", q);
      end
   endtask

   task automatic test_reset_midburst();
      int c, n, wacks;
      for (int i = 0; i < 8; i++) wbuf[i] = 32'h5500_0000 + i;
      run_burst(32'h200, 7, 1'b0, 1'b1, c);
      for (int i = 0; i < 8; i++) wbuf[i] = 32'h6600_0000 + i;
      @(negedge clk);
      mi_addr  = 32'h200;
      mi_len   = 7'd7;
      mi_rw    = 1'b0;
      mi_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mi_valid = 1'b0;
      wacks = 0;
      n = 0;
      while (wacks < 2 && n < 20) begin
         mi_wdata = wbuf[wacks];
         if (mi_wack) begin
            model[32'h200 + wacks] = wbuf[wacks];
            wacks++;
         end
         if (wacks < 2) begin
            @(negedge clk);
            n++;
         end
      end
      if (wacks < 2) begin
         checks++;
         failures++;
         $display("FAIL midburst_wack_timeout: got %0d wacks want 2", wacks);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (mi_wack !== 1'b0 || mi_ready !== 1'b1) begin
         failures++;
         $display("FAIL midburst_reset: got wack=%b ready=%b want 0 1", mi_wack, mi_ready);
      end
      rst = 1'b0;
      run_burst(32'h200, 7, 1'b1, 1'b1, c);
   endtask

   initial begin
      rst      = 1'b1;
      mi_addr  = 32'd0;
      mi_len   = 7'd0;
      mi_rw    = 1'b0;
      mi_valid = 1'b0;
      mi_wdata = 32'd0;
      wb_addr  = 2'd0;
      wb_wdata = 32'd0;
      wb_we    = 1'b0;
      wb_cyc   = 1'b0;
      test_reset();
      test_write_read();
      test_wrap();
      test_stall();
      test_counters();
      test_reset_midburst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
